// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, CCR bit positions and control-bundle bit indices for the pipeline
package cpu_pkg;
  localparam int CTRL_W = 9;
  localparam logic [4:0] ALU_NOP  = 5'b00000;
  localparam logic [4:0] ALU_NOT  = 5'b00001;
  localparam logic [4:0] ALU_CLRC = 5'b00010;
  localparam logic [4:0] ALU_INC  = 5'b00011;
  localparam logic [4:0] ALU_DEC  = 5'b00100;
  localparam logic [4:0] ALU_OUT  = 5'b00101;
  localparam logic [4:0] ALU_SETC = 5'b00110;
  localparam logic [4:0] ALU_IN   = 5'b00111;
  localparam logic [4:0] ALU_MOV  = 5'b01000;
  localparam logic [4:0] ALU_ADD  = 5'b01001;
  localparam logic [4:0] ALU_SUB  = 5'b01010;
  localparam logic [4:0] ALU_AND  = 5'b01011;
  localparam logic [4:0] ALU_OR   = 5'b01100;
  localparam logic [4:0] ALU_SHL  = 5'b01101;
  localparam logic [4:0] ALU_SHR  = 5'b01110;
  localparam logic [4:0] ALU_PUSH = 5'b01111;
  localparam logic [4:0] ALU_POP  = 5'b10000;
  localparam logic [4:0] ALU_LDM  = 5'b10001;
  localparam logic [4:0] ALU_LDD  = 5'b10010;
  localparam logic [4:0] ALU_STD  = 5'b10011;
  localparam logic [4:0] ALU_JZ   = 5'b10100;
  localparam logic [4:0] ALU_JN   = 5'b10101;
  localparam logic [4:0] ALU_JC   = 5'b10110;
  localparam logic [4:0] ALU_JMP  = 5'b10111;
  localparam logic [4:0] ALU_CALL = 5'b11000;
  localparam logic [4:0] ALU_RET  = 5'b11001;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int CTRL_REG_WR     = 8;
  localparam int CTRL_MEM_WR     = 7;
  localparam int CTRL_MEM_RD     = 6;
  localparam int CTRL_MEM_TO_REG = 5;
  localparam int CTRL_STACK      = 4;
  localparam int CTRL_DEC_SP     = 3;
  localparam int CTRL_INC_SP     = 2;
  localparam int CTRL_BRANCH     = 1;
  localparam int CTRL_RET        = 0;
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational ALU for the execute stage.
//   op/a/b/imm/in_port -> result plus flag candidates z,n,c and the enables c_valid, zn_valid
module exec_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n,
  output logic              c,
  output logic              c_valid,
  output logic              zn_valid
);
  logic [DATA_W:0] sum, diff, shl, shr, inc;
  logic [3:0]      amt;
  always_comb begin
    amt  = imm[3:0];
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    inc  = {1'b0, a} + (DATA_W+1)'(1);
    // shl top bit and shr bottom bit hold the last bit shifted out
    shl  = {1'b0, a} << amt;
    shr  = {a, 1'b0} >> amt;
    result   = '0;
    c        = 1'b0;
    c_valid  = 1'b0;
    zn_valid = 1'b0;
    case (op)
      ALU_SETC: begin c = 1'b1; c_valid = 1'b1; end
      ALU_CLRC: c_valid = 1'b1;
      ALU_NOT:  begin result = ~a; zn_valid = 1'b1; end
      ALU_INC:  begin {c, result} = inc; c_valid = 1'b1; zn_valid = 1'b1; end
      ALU_DEC:  begin result = a - DATA_W'(1); c = (a == '0); c_valid = 1'b1; zn_valid = 1'b1; end
      ALU_ADD:  begin {c, result} = sum; c_valid = 1'b1; zn_valid = 1'b1; end
      ALU_SUB:  begin {c, result} = diff; c_valid = 1'b1; zn_valid = 1'b1; end
      ALU_AND:  begin result = a & b; zn_valid = 1'b1; end
      ALU_OR:   begin result = a | b; zn_valid = 1'b1; end
      ALU_MOV:  result = a;
      ALU_IN:   result = in_port;
      ALU_SHL:  begin result = shl[DATA_W-1:0]; c = shl[DATA_W]; c_valid = (amt != '0); zn_valid = 1'b1; end
      ALU_SHR:  begin result = shr[DATA_W:1]; c = shr[0]; c_valid = (amt != '0); zn_valid = 1'b1; end
      ALU_LDM:  result = imm;
      ALU_LDD,
      ALU_STD:  result = a + imm;
      default:  result = '0;
    endcase
    z = (result == '0);
    n = result[DATA_W-1];
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 16-bit pipeline; ALU, CCR, branch resolve, OUT port, EX/MEM register.
//   in : clk, reset, valid_in, alu_op, operand_a/b, imm, alu_src, rd_in, ctrl_in, in_port, return_pc, stall, flush
//   out: ex_valid/result/store/rd/ctrl (EX/MEM), flags {C,N,Z}, out_port, br_taken/br_target (combinational)
module execute_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src,
  input  logic [RA_W-1:0]   rd_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] in_port,
  input  logic [DATA_W-1:0] return_pc,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_result,
  output logic [DATA_W-1:0] ex_store,
  output logic [RA_W-1:0]   ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [2:0]        flags,
  output logic [DATA_W-1:0] out_port,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target
);
  logic [DATA_W-1:0] b_side, alu_result, store;
  logic              alu_z, alu_n, alu_c, alu_c_valid, alu_zn_valid;
  logic              fire, jz_t, jn_t, jc_t;
  logic              valid_d, valid_q;
  logic [DATA_W-1:0] result_d, result_q, store_d, store_q, out_port_d, out_port_q;
  logic [RA_W-1:0]   rd_d, rd_q;
  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [2:0]        flags_d, flags_q;

  assign b_side = alu_src ? imm : operand_b;

  exec_alu #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .op(alu_op), .a(operand_a), .b(b_side), .imm(imm), .in_port(in_port),
    .result(alu_result), .z(alu_z), .n(alu_n), .c(alu_c),
    .c_valid(alu_c_valid), .zn_valid(alu_zn_valid)
  );

  always_comb begin
    fire      = valid_in & ~stall & ~flush & ~reset;
    jz_t      = (alu_op == ALU_JZ) & flags_q[FLAG_Z];
    jn_t      = (alu_op == ALU_JN) & flags_q[FLAG_N];
    jc_t      = (alu_op == ALU_JC) & flags_q[FLAG_C];
    br_taken  = fire & ((alu_op == ALU_JMP) | (alu_op == ALU_CALL) | jz_t | jn_t | jc_t);
    br_target = operand_a;
    store     = (alu_op == ALU_STD)  ? b_side :
                (alu_op == ALU_PUSH) ? operand_a :
                (alu_op == ALU_CALL) ? return_pc : '0;
    // a taken conditional jump consumes the flag it tested
    flags_d = flags_q;
    if (fire) begin
      if (alu_zn_valid) {flags_d[FLAG_N], flags_d[FLAG_Z]} = {alu_n, alu_z};
      if (alu_c_valid) flags_d[FLAG_C] = alu_c;
      if (jz_t) flags_d[FLAG_Z] = 1'b0;
      if (jn_t) flags_d[FLAG_N] = 1'b0;
      if (jc_t) flags_d[FLAG_C] = 1'b0;
    end
    // stall freezes the slot; anything else that does not fire becomes a bubble
    valid_d    = stall ? valid_q  : fire;
    result_d   = stall ? result_q : fire ? alu_result : '0;
    store_d    = stall ? store_q  : fire ? store : '0;
    rd_d       = stall ? rd_q     : fire ? rd_in : '0;
    ctrl_d     = stall ? ctrl_q   : fire ? ctrl_in : '0;
    out_port_d = (fire & (alu_op == ALU_OUT)) ? operand_a : out_port_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      store_q    <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      flags_q    <= '0;
      out_port_q <= '0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      store_q    <= store_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      flags_q    <= flags_d;
      out_port_q <= out_port_d;
    end
  end

  assign ex_valid  = valid_q;
  assign ex_result = result_q;
  assign ex_store  = store_q;
  assign ex_rd     = rd_q;
  assign ex_ctrl   = ctrl_q;
  assign flags     = flags_q;
  assign out_port  = out_port_q;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed stimulus, arithmetic reference model and per-cycle compare for execute_stage
module tb_execute_stage;
  import cpu_pkg::*;
  logic        clk, reset, valid_in, alu_src, stall, flush;
  logic [4:0]  alu_op;
  logic [15:0] operand_a, operand_b, imm, in_port, return_pc;
  logic [2:0]  rd_in;
  logic [8:0]  ctrl_in;
  logic        ex_valid, br_taken;
  logic [15:0] ex_result, ex_store, out_port, br_target;
  logic [2:0]  ex_rd, flags;
  logic [8:0]  ex_ctrl;

  execute_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_op(alu_op),
    .operand_a(operand_a), .operand_b(operand_b), .imm(imm), .alu_src(alu_src),
    .rd_in(rd_in), .ctrl_in(ctrl_in), .in_port(in_port), .return_pc(return_pc),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store(ex_store), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .flags(flags),
    .out_port(out_port), .br_taken(br_taken), .br_target(br_target)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  bit          started = 0;
  bit          m_valid, mz, mn, mc;
  logic [15:0] m_res, m_store, m_out;
  logic [2:0]  m_rd;
  logic [8:0]  m_ctrl;
  int          av, bv, iv, res, st;
  bit          upd_zn, upd_c, cv;

  function automatic bit pred_taken();
    if (reset || !valid_in || stall || flush) return 0;
    return alu_op == ALU_JMP || alu_op == ALU_CALL || (alu_op == ALU_JZ && mz) ||
           (alu_op == ALU_JN && mn) || (alu_op == ALU_JC && mc);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      m_valid = 0; m_res = 0; m_store = 0; m_rd = 0; m_ctrl = 0;
      mz = 0; mn = 0; mc = 0; m_out = 0;
    end else if (!stall) begin
      if (valid_in && !flush) begin
        av = int'(operand_a); bv = alu_src ? int'(imm) : int'(operand_b); iv = int'(imm);
        res = 0; st = 0; upd_zn = 0; upd_c = 0; cv = 0;
        case (alu_op)
          ALU_SETC: begin upd_c = 1; cv = 1; end
          ALU_CLRC: begin upd_c = 1; cv = 0; end
          ALU_NOT:  begin res = 65535 - av; upd_zn = 1; end
          ALU_INC:  begin res = (av + 1) % 65536; cv = (av == 65535); upd_c = 1; upd_zn = 1; end
          ALU_DEC:  begin res = (av + 65535) % 65536; cv = (av == 0); upd_c = 1; upd_zn = 1; end
          ALU_ADD:  begin res = (av + bv) % 65536; cv = (av + bv) >= 65536; upd_c = 1; upd_zn = 1; end
          ALU_SUB:  begin res = (av - bv + 65536) % 65536; cv = av < bv; upd_c = 1; upd_zn = 1; end
          ALU_AND:  begin res = av & bv; upd_zn = 1; end
          ALU_OR:   begin res = av | bv; upd_zn = 1; end
          ALU_MOV:  res = av;
          ALU_IN:   res = int'(in_port);
          ALU_SHL: begin
            res = av; upd_zn = 1; upd_c = (iv % 16) != 0;
            for (int k = 0; k < iv % 16; k++) begin cv = res >= 32768; res = (res * 2) % 65536; end
          end
          ALU_SHR: begin
            res = av; upd_zn = 1; upd_c = (iv % 16) != 0;
            for (int k = 0; k < iv % 16; k++) begin cv = (res % 2) == 1; res = res / 2; end
          end
          ALU_LDM:  res = iv;
          ALU_LDD:  res = (av + iv) % 65536;
          ALU_STD:  begin res = (av + iv) % 65536; st = bv; end
          ALU_PUSH: st = av;
          ALU_CALL: st = int'(return_pc);
          ALU_OUT:  m_out = operand_a;
          ALU_JZ:   mz = 0;
          ALU_JN:   mn = 0;
          ALU_JC:   mc = 0;
          default:  res = 0;
        endcase
        if (upd_zn) begin mz = (res == 0); mn = (res >= 32768); end
        if (upd_c) mc = cv;
        m_valid = 1; m_res = res[15:0]; m_store = st[15:0]; m_rd = rd_in; m_ctrl = ctrl_in;
      end else begin
        m_valid = 0; m_res = 0; m_store = 0; m_rd = 0; m_ctrl = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("ex_result", 32'(ex_result), 32'(m_res));
      chk("ex_store", 32'(ex_store), 32'(m_store));
      chk("ex_rd", 32'(ex_rd), 32'(m_rd));
      chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
      chk("flags", 32'(flags), 32'({mc, mn, mz}));
      chk("out_port", 32'(out_port), 32'(m_out));
      chk("br_taken", 32'(br_taken), 32'(pred_taken()));
      chk("br_target", 32'(br_target), 32'(operand_a));
    end
  end

  task automatic set_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] i, input logic src);
    valid_in = 1; alu_op = op; operand_a = a; operand_b = b; imm = i; alu_src = src;
    rd_in = op[2:0]; ctrl_in = {4'b1010, op}; return_pc = a + 16'd1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] i, input logic src);
    set_op(op, a, b, i, src);
    tick();
  endtask

  initial begin
    clk = 0; reset = 1; stall = 0; flush = 0; in_port = 16'h1234;
    set_op(ALU_JMP, 16'h0077, 16'h0, 16'h0, 0);
    #1;
    chk("lit_reset_br", 32'(br_taken), 0);
    tick(); tick();
    chk("lit_reset_valid", 32'(ex_valid), 0);
    chk("lit_reset_flags", 32'(flags), 0);
    reset = 0;
    issue(ALU_ADD, 16'hFFFF, 16'h0001, 16'h0, 0);
    chk("lit_add_res", 32'(ex_result), 32'h0000);
    chk("lit_add_flags", 32'(flags), 32'b101);
    issue(ALU_SUB, 16'h0003, 16'h0005, 16'h0, 0);
    chk("lit_sub_res", 32'(ex_result), 32'hFFFE);
    chk("lit_sub_flags", 32'(flags), 32'b110);
    set_op(ALU_JN, 16'h0040, 16'h0, 16'h0, 0);
    #1;
    chk("lit_jn_taken", 32'(br_taken), 1);
    chk("lit_jn_target", 32'(br_target), 32'h0040);
    tick();
    chk("lit_jn_flags", 32'(flags), 32'b100);
    issue(ALU_SHL, 16'h8001, 16'h0, 16'h0001, 1);
    chk("lit_shl_res", 32'(ex_result), 32'h0002);
    chk("lit_shl_flags", 32'(flags), 32'b100);
    issue(ALU_SHL, 16'h0002, 16'h0, 16'h0000, 1);
    chk("lit_shl0_res", 32'(ex_result), 32'h0002);
    chk("lit_shl0_flags", 32'(flags), 32'b100);
    set_op(ALU_JZ, 16'h0050, 16'h0, 16'h0, 0);
    #1;
    chk("lit_jz_nt", 32'(br_taken), 0);
    tick();
    chk("lit_jz_flags", 32'(flags), 32'b100);
    issue(ALU_CLRC, 16'h0, 16'h0, 16'h0, 0);
    chk("lit_clrc", 32'(flags), 32'b000);
    issue(ALU_SETC, 16'h0, 16'h0, 16'h0, 0);
    chk("lit_setc", 32'(flags), 32'b100);
    set_op(ALU_JC, 16'h0060, 16'h0, 16'h0, 0);
    #1;
    chk("lit_jc_taken", 32'(br_taken), 1);
    tick();
    chk("lit_jc_flags", 32'(flags), 32'b000);
    set_op(ALU_ADD, 16'h0001, 16'h0002, 16'h0, 0);
    stall = 1;
    tick(); tick(); tick();
    chk("lit_stall_res", 32'(ex_result), 32'h0000);
    set_op(ALU_JMP, 16'h0099, 16'h0, 16'h0, 0);
    #1;
    chk("lit_stall_br", 32'(br_taken), 0);
    set_op(ALU_ADD, 16'h0001, 16'h0002, 16'h0, 0);
    stall = 0;
    tick();
    chk("lit_stall_release", 32'(ex_result), 32'h0003);
    set_op(ALU_CALL, 16'h0100, 16'h0, 16'h0, 0);
    flush = 1;
    #1;
    chk("lit_flush_br", 32'(br_taken), 0);
    tick();
    chk("lit_flush_valid", 32'(ex_valid), 0);
    flush = 0;
    issue(ALU_CALL, 16'h0200, 16'h0, 16'h0, 0);
    chk("lit_call_store", 32'(ex_store), 32'h0201);
    issue(ALU_NOT, 16'h00FF, 16'h0, 16'h0, 0);
    issue(ALU_INC, 16'hFFFF, 16'h0, 16'h0, 0);
    issue(ALU_DEC, 16'h0000, 16'h0, 16'h0, 0);
    chk("lit_dec_res", 32'(ex_result), 32'hFFFF);
    issue(ALU_AND, 16'hF0F0, 16'h0FF0, 16'h0, 0);
    issue(ALU_OR, 16'h0000, 16'h0000, 16'h0, 0);
    issue(ALU_JZ, 16'h0300, 16'h0, 16'h0, 0);
    issue(ALU_MOV, 16'hABCD, 16'h0, 16'h0, 0);
    issue(ALU_IN, 16'h0, 16'h0, 16'h0, 0);
    issue(ALU_LDM, 16'h0, 16'h0, 16'h4321, 1);
    issue(ALU_LDD, 16'h1000, 16'h0, 16'h0020, 1);
    issue(ALU_STD, 16'h2000, 16'hBEEF, 16'h0004, 0);
    chk("lit_std_store", 32'(ex_store), 32'hBEEF);
    issue(ALU_PUSH, 16'h5555, 16'h0, 16'h0, 0);
    issue(ALU_POP, 16'h6666, 16'h0, 16'h0, 0);
    issue(ALU_RET, 16'h7777, 16'h0, 16'h0, 0);
    issue(ALU_OUT, 16'h5A5A, 16'h0, 16'h0, 0);
    chk("lit_out_port", 32'(out_port), 32'h5A5A);
    issue(ALU_SHR, 16'h0003, 16'h0, 16'h0001, 1);
    issue(ALU_SHR, 16'h8000, 16'h0, 16'h000F, 1);
    issue(ALU_SUB, 16'h0010, 16'h0000, 16'h0010, 1);
    issue(ALU_ADD, 16'h7000, 16'h0, 16'h1000, 1);
    issue(5'b11111, 16'h1111, 16'h2222, 16'h3333, 0);
    valid_in = 0;
    tick();
    set_op(ALU_OUT, 16'h1111, 16'h0, 16'h0, 0);
    reset = 1;
    tick();
    chk("lit_midreset_valid", 32'(ex_valid), 0);
    chk("lit_midreset_flags", 32'(flags), 0);
    chk("lit_midreset_out", 32'(out_port), 0);
    reset = 0;
    valid_in = 0;
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
